// File: rtl/sc_fifo_flags.sv
// -----------------------------------------------------------------------------
// sc_fifo_flags
//
// Single-clock FIFO with built-in storage. All status flags are registered and
// derived from the next fill count, so they always agree with usedw_o.
// Overflow and underflow are sticky. The read port runs either in normal mode
// (registered q) or in show-ahead mode (head word visible combinationally).
//
// Ports
//   clk_i           rising-edge clock for all logic
//   srst_n_i        synchronous reset, active low
//   data_i          write data
//   wrreq_i         write request; dropped while full_o is set
//   rdreq_i         read request (show-ahead: head acknowledge); dropped while
//                   empty_o is set
//   q_o             read data
//   empty_o         usedw_o == 0
//   full_o          usedw_o == DEPTH
//   almost_empty_o  usedw_o <  ALMOST_EMPTY_VALUE
//   almost_full_o   usedw_o >= ALMOST_FULL_VALUE
//   usedw_o         words stored, 0..DEPTH inclusive
//   ovf_o           sticky: write attempted while full
//   udf_o           sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sc_fifo_flags #(
    parameter int DWIDTH             = 8,
    parameter int AWIDTH             = 4,
    parameter int SHOWAHEAD          = 0,
    parameter int ALMOST_FULL_VALUE  = 12,
    parameter int ALMOST_EMPTY_VALUE = 4
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
    output logic              almost_full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              ovf_o,
    output logic              udf_o
);

    localparam int DEPTH = 2 ** AWIDTH;

    // Thresholds cast to the count width so every comparison is same-width.
    localparam logic [AWIDTH:0]   DEPTH_CNT = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0]   AF_CNT    = (AWIDTH + 1)'(ALMOST_FULL_VALUE);
    localparam logic [AWIDTH:0]   AE_CNT    = (AWIDTH + 1)'(ALMOST_EMPTY_VALUE);
    localparam logic [AWIDTH:0]   CNT_ONE   = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE   = AWIDTH'(1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   count;
    logic [AWIDTH:0]   next_count;
    logic              wr_en;
    logic              rd_en;

    // Gating uses only the registered flags: a write at full is dropped even
    // when a read is accepted in the same cycle, and vice versa at empty.
    // Reset also blocks both so a request during reset has no effect at all.
    assign wr_en = srst_n_i & wrreq_i & ~full_o;
    assign rd_en = srst_n_i & rdreq_i & ~empty_o;

    // NOTE: next_count gets its default first, so every path assigns it and no latch is inferred.
    always_comb begin
        next_count = count;
        if (wr_en && !rd_en) begin
            next_count = count + CNT_ONE;
        end else if (rd_en && !wr_en) begin
            next_count = count - CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            empty_o        <= 1'b1;
            full_o         <= 1'b0;
            almost_empty_o <= 1'b1;
            almost_full_o  <= 1'b0;
            ovf_o          <= 1'b0;
            udf_o          <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count          <= next_count;
            empty_o        <= (next_count == '0);
            full_o         <= (next_count == DEPTH_CNT);
            almost_empty_o <= (next_count < AE_CNT);
            almost_full_o  <= (next_count >= AF_CNT);
            if (wrreq_i && full_o) begin
                ovf_o <= 1'b1;
            end
            if (rdreq_i && empty_o) begin
                udf_o <= 1'b1;
            end
        end
    end

    assign usedw_o = count;

    // NOTE: the storage array has no reset; after reset the pointers make old contents unreachable.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_show_ahead
            // Head word is visible as soon as it is written; undefined while empty.
            assign q_o = mem[rd_ptr];
        end else begin : g_normal
            logic [DWIDTH-1:0] q_reg;

            always_ff @(posedge clk_i) begin
                if (!srst_n_i) begin
                    q_reg <= '0;
                end else if (rd_en) begin
                    q_reg <= mem[rd_ptr];
                end
            end

            assign q_o = q_reg;
        end
    endgenerate

endmodule
